// File: rtl/io_bcd_display.sv
// Binary-to-decimal seven-segment driver using a sequential double-dabble engine.
// Optional macro IO_BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module io_bcd_display #(
    parameter int IN_W    = 20,
    parameter int NUM_DIG = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            value_in,
    output logic [7*NUM_DIG-1:0]   hex_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int SR_W  = 4*(NUM_DIG+1) + IN_W;
    localparam int CNT_W = $clog2(IN_W+1);
    localparam logic [7*NUM_DIG-1:0] ALL_BLANK = {NUM_DIG{7'h7F}};
    localparam logic [7*NUM_DIG-1:0] ALL_DASH  = {NUM_DIG{7'h3F}};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

    state_t             r_state;
    logic [31:0]        r_last_val;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pending;

    logic [SR_W-1:0]    w_adj;
    logic [7*NUM_DIG-1:0] w_hex;
    logic               w_ovf;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble, applied before each shift
    always_comb begin
        w_adj = r_sr;
        for (int k = 0; k <= NUM_DIG; k++) begin
            if (r_sr[IN_W+4*k +: 4] >= 4'd5)
                w_adj[IN_W+4*k +: 4] = r_sr[IN_W+4*k +: 4] + 4'd3;
        end
    end

    assign w_ovf = ((r_last_val >> IN_W) != 32'd0) ||
                   (r_sr[IN_W+4*NUM_DIG +: 4] != 4'd0);

    always_comb begin
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
        logic w_seen;
        w_seen = 1'b0;
`endif
        w_hex = ALL_BLANK;
        for (int k = NUM_DIG-1; k >= 0; k--) begin
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
            if (r_sr[IN_W+4*k +: 4] != 4'd0)
                w_seen = 1'b1;
            if (w_seen || k == 0)
                w_hex[7*k +: 7] = seg7(r_sr[IN_W+4*k +: 4]);
`else
            w_hex[7*k +: 7] = seg7(r_sr[IN_W+4*k +: 4]);
`endif
        end
        if (w_ovf)
            w_hex = ALL_DASH;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_val <= 32'd0;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_pending  <= 1'b1;
            hex_out    <= ALL_BLANK;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending || value_in != r_last_val) begin
                        r_last_val <= value_in;
                        r_sr       <= {{(4*(NUM_DIG+1)){1'b0}}, value_in[IN_W-1:0]};
                        r_cnt      <= CNT_W'(IN_W);
                        r_pending  <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= {w_adj[SR_W-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1))
                        r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    hex_out  <= w_hex;
                    overflow <= w_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bcd_display.sv
// Self-checking bench for io_bcd_display against a decimal arithmetic model.
module tb_io_bcd_display;

    localparam int IN_W    = 20;
    localparam int NUM_DIG = 6;
    localparam int HW      = 7*NUM_DIG;

    logic          clock;
    logic          reset;
    logic [31:0]   value_in;
    logic [HW-1:0] hex_out;
    logic          busy;
    logic          done;
    logic          overflow;

    int vectors;
    int miscompares;

    io_bcd_display #(.IN_W(IN_W), .NUM_DIG(NUM_DIG)) dut (
        .clock    (clock),
        .reset    (reset),
        .value_in (value_in),
        .hex_out  (hex_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: decimal digits via division, segment lookup table
    function automatic void model(input logic [31:0] v, output logic [HW-1:0] hex, output logic ov);
        logic [6:0] seg [10];
        int unsigned low;
        int unsigned n;
        int unsigned limit;
        int top;
        seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        low   = v % (32'd1 << IN_W);
        limit = 1;
        for (int i = 0; i < NUM_DIG; i++) limit = limit * 10;
        ov = (v >= (32'd1 << IN_W)) || (low >= limit);
        n = low;
        top = 0;
        for (int k = 0; k < NUM_DIG; k++) begin
            hex[7*k +: 7] = seg[n % 10];
            if (n % 10 != 0) top = k;
            n = n / 10;
        end
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
        for (int k = 1; k < NUM_DIG; k++)
            if (k > top) hex[7*k +: 7] = 7'h7F;
`endif
        if (ov) hex = {NUM_DIG{7'h3F}};
    endfunction

    task automatic wait_done(output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge clock);
            cyc++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        int cyc; bit got; int extra;
        logic [HW-1:0] eh; logic eo;
        value_in = 32'd0;
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (hex_out !== {NUM_DIG{7'h7F}} || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: hex=%h busy=%b done=%b ovf=%b, want hex=%h 0 0 0",
                     hex_out, busy, done, overflow, {NUM_DIG{7'h7F}});
        end
        reset = 1'b0;
        wait_done(cyc, got);
        model(32'd0, eh, eo);
        vectors++;
        if (!got || cyc != 22) begin
            miscompares++;
            $display("[TB] FAIL reset_latency: got=%0b cycles=%0d, want done at 22", got, cyc);
        end
        vectors++;
        if (hex_out !== eh || overflow !== eo) begin
            miscompares++;
            $display("[TB] FAIL zero_value: hex=%h ovf=%b, want hex=%h ovf=%b", hex_out, overflow, eh, eo);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_single_done: extra done pulses=%0d, want 0", extra);
        end
    endtask

    task automatic test_basic;
        int busy_cyc; bit got; int extra;
        logic [HW-1:0] eh; logic eo;
        value_in = 32'd123456;
        busy_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (done) got = 1'b1;
            else if (busy) busy_cyc++;
        end
        model(32'd123456, eh, eo);
        vectors++;
        if (!got || busy_cyc != 21) begin
            miscompares++;
            $display("[TB] FAIL busy_length: got=%0b busy=%0d, want 21", got, busy_cyc);
        end
        vectors++;
        if (hex_out !== eh || hex_out !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02} || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL value_123456: hex=%h ovf=%b, want hex=%h ovf=0", hex_out, overflow, eh);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) extra++;
        end
        vectors++;
        if (extra != 0 || hex_out !== eh) begin
            miscompares++;
            $display("[TB] FAIL hold_stable: extra done=%0d hex=%h, want 0 and %h", extra, hex_out, eh);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] vals [3];
        int cyc; bit got;
        logic [HW-1:0] eh; logic eo;
        vals = '{32'd999999, 32'd1000000, 32'h0010_0005};
        for (int i = 0; i < 3; i++) begin
            value_in = vals[i];
            wait_done(cyc, got);
            model(vals[i], eh, eo);
            vectors++;
            if (!got || hex_out !== eh || overflow !== eo) begin
                miscompares++;
                $display("[TB] FAIL overflow_%0d: got=%0b hex=%h ovf=%b, want hex=%h ovf=%b",
                         i, got, hex_out, overflow, eh, eo);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc; bit got;
        logic [HW-1:0] eh; logic eo;
        value_in = 32'd42;
        repeat (6) @(negedge clock);
        value_in = 32'd7;
        wait_done(cyc, got);
        model(32'd42, eh, eo);
        vectors++;
        if (!got || hex_out !== eh) begin
            miscompares++;
            $display("[TB] FAIL mid_change_first: got=%0b hex=%h, want %h", got, hex_out, eh);
        end
        @(negedge clock);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL restart_gap: busy=%b one cycle after done, want 1", busy);
        end
        wait_done(cyc, got);
        model(32'd7, eh, eo);
        vectors++;
        if (!got || cyc != 21 || hex_out !== eh || hex_out[6:0] !== 7'h78) begin
            miscompares++;
            $display("[TB] FAIL mid_change_second: got=%0b cyc=%0d hex=%h, want cyc=21 hex=%h",
                     got, cyc, hex_out, eh);
        end
    endtask

    task automatic test_reset_mid;
        int cyc; bit got;
        logic [HW-1:0] eh; logic eo;
        value_in = 32'd65535;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (hex_out !== {NUM_DIG{7'h7F}} || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: hex=%h busy=%b done=%b ovf=%b, want blank 0 0 0",
                     hex_out, busy, done, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        wait_done(cyc, got);
        model(32'd65535, eh, eo);
        vectors++;
        if (!got || cyc != 22 || hex_out !== eh) begin
            miscompares++;
            $display("[TB] FAIL reset_recover: got=%0b cyc=%0d hex=%h, want cyc=22 hex=%h",
                     got, cyc, hex_out, eh);
        end
    endtask

    task automatic test_random;
        int cyc; bit got;
        logic [31:0] v;
        logic [HW-1:0] eh; logic eo;
        for (int i = 0; i < 2000; i++) begin
            v = 32'($urandom_range(0, (1 << IN_W) - 1));
            if (v == value_in) v = v ^ 32'd1;
            value_in = v;
            wait_done(cyc, got);
            model(v, eh, eo);
            vectors++;
            if (!got || hex_out !== eh || overflow !== eo) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: v=%0d got=%0b hex=%h ovf=%b, want hex=%h ovf=%b",
                         i, v, got, hex_out, overflow, eh, eo);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        value_in    = 32'd0;
        test_reset;
        test_basic;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_bcd_display.md
Name: io_bcd_display

Overview:
- Downstream consumer of the computer's memory-mapped output ports (op0/op1/op2); one instance per port.
- Converts the binary port value to decimal with a sequential double-dabble (shift-and-add-3) engine.
- Drives NUM_DIG active-low seven-segment digits on the board, so program results appear in decimal without the CPU doing conversion.

Parameters:
- IN_W, 20, number of low bits of value_in converted (unsigned); must satisfy 10^NUM_DIG > 2^IN_W / 2
- NUM_DIG, 6, number of displayed decimal digits

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- value_in  input  32  output-port word from the data memory I/O block
- hex_out  output  7*NUM_DIG  segment codes; digit k at [7k+6:7k], digit 0 = least significant; bit0=a … bit6=g, active-low
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when hex_out is updated
- overflow  output  1  high when the displayed value could not be represented

Behaviour:
- Reset (async, active-high):
  - hex_out = all digits blank (7'h7F).
  - busy = 0, done = 0, overflow = 0.
  - State = IDLE, pending = 1, last_val = 0.
- Registers:
  - last_val[31:0]: value last converted.
  - shift register: (NUM_DIG+1) BCD digits concatenated with IN_W binary bits.
  - bit counter: 0..IN_W.
  - pending flag.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - If pending = 1 or value_in != last_val:
    - Capture value_in into last_val.
    - Load the shift register with BCD digits = 0 and binary = value_in[IN_W-1:0].
    - Set counter = IN_W, clear pending, go to SHIFT.
  - busy goes high in the cycle after capture.
- SHIFT, one bit per cycle:
  - Every BCD nibble ≥ 5 gets +3 (nibbles independent, 4-bit result).
  - Then the whole register shifts left by 1 and counter decrements.
  - When counter reaches 0 after the shift, go to UPDATE.
- UPDATE, one cycle:
  - overflow = (last_val[31:IN_W] != 0) OR (extra BCD digit NUM_DIG != 0).
  - If overflow, every digit shows dash 7'h3F. Otherwise digit k shows the BCD digit k encoding.
  - Pulse done = 1, go to IDLE.
  - busy = 0 in the cycle done is high.
- Latency: value_in changes before edge N (sampled in IDLE) → hex_out and done valid after edge N+IN_W+1. With the default, 21 cycles of busy.
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - blank = 7F, dash = 3F.
- value_in changing during SHIFT/UPDATE:
  - Ignored by the engine.
  - At the next IDLE cycle the mismatch with last_val triggers a new conversion. The final display always reflects the latest stable value.
- Back-to-back: a new conversion may start in the IDLE cycle immediately after UPDATE. There is no dead time beyond that single IDLE cycle.
- Reset mid-conversion: immediate return to the reset state. Because pending = 1, a fresh conversion starts on the first clock after reset deasserts.
- hex_out holds its value between updates. It never shows partial conversion results.
- Value 0: all digits show "0" (subject to the optional feature).
- Max in-range value (default): 999999 → "999999", overflow = 0. Values 1000000–1048575 → dashes, overflow = 1.

Optional Feature:
- Macro: IO_BCD_LEADING_ZERO_BLANK_EN.
- Defined: in UPDATE (non-overflow), digits above the most significant non-zero digit show blank (7F). Digit 0 is always shown, so 0 displays as a single "0".
- Undefined: all NUM_DIG digits are always shown, with leading zeros.
- Overflow dashes are unaffected either way.

Test Plan:
- Reset then hold value_in=0 → after 22 clocks: done pulsed once, overflow=0, hex_out all digits 40 (macro undefined); with macro, digit0=40 and digits1–5=7F.
- value_in=123456 → busy high 21 cycles, then digits5..0 = 79,24,30,19,12,02; one done pulse; no further done while value_in is held.
- value_in=999999 then 1000000 → first gives all 10s, overflow=0; second gives all 3F, overflow=1. Then value_in=32'h0010_0005 (upper bits set) → all 3F, overflow=1.
- value_in=42 changed to 7 at cycle 5 of the conversion → first done shows 42. Second conversion starts the cycle after UPDATE; second done shows 7 (digit0=78).
- Assert reset at cycle 10 of converting 65535 → hex_out immediately all 7F, busy=0. After release with value_in=65535, display reaches 0,6,5,5,3,5 (40,02,12,12,30,12).
- Random 2000 values in 0..2^20-1, each held until done → digits match a decimal model; overflow exactly when value ≥ 1000000.
